// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// run-time parity/stop configuration, break detection and a one-entry valid/ready output.
module uart_rx_os #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                 SysClk,
    input  logic                 Rst_n,
    input  logic                 Rx,
    input  logic [1:0]           Parity_Mode,
    input  logic                 Stop_Sel,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int CLKS_PER_TICK = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SAMP_W        = $clog2(OVERSAMPLE);
    localparam int BIT_W         = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] sr,
                                                      input logic b);
        if (MSB_FIRST) begin
            return {sr[DATA_BITS-2:0], b};
        end else begin
            return {b, sr[DATA_BITS-1:1]};
        end
    endfunction

    state_t                state_q, state_d;
    logic                  sync1_q, rx_s_q, rx_prev_q;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SAMP_W-1:0]     samp_cnt_q, samp_cnt_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  zero_q, zero_d;
    logic                  par_err_q, par_err_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]  data_out_q, data_out_d;
    logic [2:0]            rx_err_q, rx_err_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  tick_s, start_edge_s, decide_s, bit_s, par_en_s, brk_s;
    logic                  commit_s;
    logic [2:0]            commit_err_s;

    assign tick_s       = (tick_cnt_q == TICK_LAST);
    assign start_edge_s = (state_q == ST_IDLE) & rx_prev_q & ~rx_s_q;
    assign decide_s     = tick_s & (samp_cnt_q == SAMP_C) &
                          (state_q != ST_IDLE) & (state_q != ST_BRK_WAIT);
    assign bit_s        = majority3(s0_q, s1_q, rx_s_q);
    assign par_en_s     = (par_mode_q == 2'b01) | (par_mode_q == 2'b10);
    // A break needs every bit so far low, including the first stop bit being decided now.
    assign brk_s        = zero_q & ~bit_s;

    // Rx synchroniser and previous-sample register for falling-edge detection
    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= Rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // FSM state register
    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) state_d = ST_START;
                else              state_d = ST_IDLE;
            end
            ST_START: begin
                if (decide_s) state_d = bit_s ? ST_IDLE : ST_DATA;
                else          state_d = ST_START;
            end
            ST_DATA: begin
                if (decide_s && (bit_cnt_q == BIT_LAST)) state_d = par_en_s ? ST_PARITY : ST_STOP;
                else                                     state_d = ST_DATA;
            end
            ST_PARITY: begin
                if (decide_s) state_d = ST_STOP;
                else          state_d = ST_PARITY;
            end
            ST_STOP: begin
                if (decide_s && !stop_cnt_q && brk_s)     state_d = ST_BRK_WAIT;
                else if (decide_s && stop_cnt_q == stop2_q) state_d = ST_IDLE;
                else                                        state_d = ST_STOP;
            end
            ST_BRK_WAIT: begin
                if (rx_s_q) state_d = ST_IDLE;
                else        state_d = ST_BRK_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-state: timing, sampling, shifting, flags and commit
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_mode_d   = par_mode_q;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
        zero_d       = zero_q;
        par_err_d    = par_err_q;
        frame_err_d  = frame_err_q;
        data_out_d   = data_out_q;
        rx_err_d     = rx_err_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        commit_s     = 1'b0;
        commit_err_s = 3'b000;

        if (start_edge_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
            samp_cnt_d = {SAMP_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
            samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? {SAMP_W{1'b0}} : samp_cnt_q + SAMP_W'(1);
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        if (tick_s && samp_cnt_q == SAMP_A) s0_d = rx_s_q;
        else                                s0_d = s0_q;
        if (tick_s && samp_cnt_q == SAMP_B) s1_d = rx_s_q;
        else                                s1_d = s1_q;

        if (decide_s) begin
            case (state_q)
                ST_START: begin
                    if (!bit_s) begin
                        bit_cnt_d   = {BIT_W{1'b0}};
                        par_mode_d  = Parity_Mode;
                        stop2_d     = Stop_Sel;
                        stop_cnt_d  = 1'b0;
                        zero_d      = 1'b1;
                        par_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                    end else begin
                        zero_d = zero_q;
                    end
                end
                ST_DATA: begin
                    shift_d   = shift_in(shift_q, bit_s);
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    zero_d    = zero_q & ~bit_s;
                end
                ST_PARITY: begin
                    par_err_d = bit_s ^ calc_parity(shift_q) ^ (par_mode_q == 2'b10);
                    zero_d    = zero_q & ~bit_s;
                end
                ST_STOP: begin
                    if (!stop_cnt_q && brk_s) begin
                        commit_s     = 1'b1;
                        commit_err_s = 3'b001;
                    end else if (stop_cnt_q == stop2_q) begin
                        commit_s     = 1'b1;
                        commit_err_s = {frame_err_q | ~bit_s, par_err_q, 1'b0};
                    end else begin
                        frame_err_d = frame_err_q | ~bit_s;
                        stop_cnt_d  = 1'b1;
                    end
                end
                default: begin
                    commit_s = 1'b0;
                end
            endcase
        end else begin
            commit_s = 1'b0;
        end

        if (valid_q && Data_Ready) valid_d = 1'b0;
        else                       valid_d = valid_q;

        // A word arriving while the register drains in the same cycle replaces it cleanly.
        if (commit_s) begin
            if (!valid_q || Data_Ready) begin
                data_out_d = shift_q;
                rx_err_d   = commit_err_s;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            tick_cnt_q  <= {TICK_W{1'b0}};
            samp_cnt_q  <= {SAMP_W{1'b0}};
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            bit_cnt_q   <= {BIT_W{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            par_mode_q  <= 2'b00;
            stop2_q     <= 1'b0;
            stop_cnt_q  <= 1'b0;
            zero_q      <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_out_q  <= {DATA_BITS{1'b0}};
            rx_err_q    <= 3'b000;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_mode_q  <= par_mode_d;
            stop2_q     <= stop2_d;
            stop_cnt_q  <= stop_cnt_d;
            zero_q      <= zero_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            data_out_q  <= data_out_d;
            rx_err_q    <= rx_err_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign Data_Out   = data_out_q;
    assign Rx_Error   = rx_err_q;
    assign Data_Valid = valid_q;
    assign Overrun    = overrun_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed cases plus randomized frames
// scored against a frame-level reference model.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 160;

    logic       SysClk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Rx = 1'b1;
    logic [1:0] Parity_Mode = 2'b00;
    logic       Stop_Sel = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Valid;
    logic       Data_Ready = 1'b1;
    logic       Overrun;
    logic       Busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    int vld_cnt = 0;
    logic [10:0] got_q[$];

    uart_rx_os #(
        .SYSCLK_RATE(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
        .DATA_BITS(8), .MSB_FIRST(1'b1)
    ) dut (
        .SysClk(SysClk), .Rst_n(Rst_n), .Rx(Rx),
        .Parity_Mode(Parity_Mode), .Stop_Sel(Stop_Sel),
        .Data_Out(Data_Out), .Rx_Error(Rx_Error), .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 SysClk = ~SysClk;

    // Record every consumed word, overrun cycles and valid cycles
    always @(negedge SysClk) begin
        if (Rst_n) begin
            if (Data_Valid && Data_Ready) got_q.push_back({Data_Out, Rx_Error});
            if (Overrun) ovr_cnt++;
            if (Data_Valid) vld_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_for(input logic [7:0] d, input logic [1:0] pm);
        return (^d) ^ (pm == 2'b10);
    endfunction

    // Reference: received word and {frame, parity, break} flags for a transmitted frame
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic [1:0] pm,
                                                input logic ss, input logic pbit,
                                                input logic s1, input logic s2);
        logic pen;
        pen = (pm == 2'b01) || (pm == 2'b10);
        if (d == 8'h00 && (!pen || !pbit) && !s1) return {8'h00, 3'b001};
        return {d, (!s1 || (ss && !s2)), (pen && (pbit != par_for(d, pm))), 1'b0};
    endfunction

    task automatic drive_rx(input logic b, input int n);
        Rx = b;
        repeat (n) @(posedge SysClk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ss,
                              input logic pbit, input logic s1, input logic s2,
                              input int noise_idx);
        logic b;
        Parity_Mode = pm;
        Stop_Sel    = ss;
        drive_rx(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            b = d[7-i];
            if (i == noise_idx) begin
                drive_rx(b, 75);
                drive_rx(~b, 10);
                drive_rx(b, 75);
            end else begin
                drive_rx(b, BIT_CLKS);
            end
        end
        if (pm == 2'b01 || pm == 2'b10) drive_rx(pbit, BIT_CLKS);
        drive_rx(s1, BIT_CLKS);
        if (ss) drive_rx(s2, BIT_CLKS);
        Rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [10:0] exp);
        logic [10:0] w;
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 400) begin
            @(posedge SysClk);
            n++;
        end
        #1;
        check_eq({tag, "_words"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check_eq({tag, "_data"}, w[10:3], exp[10:3]);
            check_eq({tag, "_err"}, w[2:0], exp[2:0]);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] pm;
        logic       ss, pbit, s1, s2;
        logic [10:0] exp;
        int gap;

        repeat (5) @(posedge SysClk);
        @(negedge SysClk);
        check_eq("rst_data", Data_Out, 8'h00);
        check_eq("rst_err", Rx_Error, 3'b000);
        check_eq("rst_valid", Data_Valid, 1'b0);
        check_eq("rst_ovr", Overrun, 1'b0);
        check_eq("rst_busy", Busy, 1'b0);
        Rst_n = 1'b1;
        drive_rx(1'b1, 20);

        vld_cnt = 0;
        send_frame(8'hA5, 2'b01, 1'b1, par_for(8'hA5, 2'b01), 1'b1, 1'b1, -1);
        expect_word("even_a5", {8'hA5, 3'b000});
        drive_rx(1'b1, 20);
        check_eq("a5_valid_cycles", vld_cnt, 1);

        send_frame(8'hAA, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        expect_word("even_aa_bad", {8'hAA, 3'b010});
        send_frame(8'hAA, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        expect_word("odd_aa", {8'hAA, 3'b000});

        send_frame(8'h55, 2'b01, 1'b1, par_for(8'h55, 2'b01), 1'b0, 1'b0, -1);
        expect_word("frame_55", {8'h55, 3'b100});
        drive_rx(1'b1, 40);

        Parity_Mode = 2'b01;
        Stop_Sel    = 1'b1;
        drive_rx(1'b0, 15 * BIT_CLKS);
        check_eq("brk_busy_hi", Busy, 1'b1);
        expect_word("break", {8'h00, 3'b001});
        drive_rx(1'b1, 5);
        check_eq("brk_busy_lo", Busy, 1'b0);
        send_frame(8'h3C, 2'b01, 1'b1, par_for(8'h3C, 2'b01), 1'b1, 1'b1, -1);
        expect_word("after_brk", {8'h3C, 3'b000});

        drive_rx(1'b0, 40);
        drive_rx(1'b1, BIT_CLKS);
        check_eq("glitch_busy", Busy, 1'b0);
        check_eq("glitch_words", got_q.size(), 0);

        send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        expect_word("noise", {8'hC3, 3'b000});

        Data_Ready = 1'b0;
        ovr_cnt    = 0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        drive_rx(1'b1, 4);
        check_eq("ovr_valid", Data_Valid, 1'b1);
        check_eq("ovr_data", Data_Out, 8'h11);
        check_eq("ovr_pulses", ovr_cnt, 1);
        Data_Ready = 1'b1;
        @(posedge SysClk);
        #1 Data_Ready = 1'b0;
        @(negedge SysClk);
        check_eq("drain_valid", Data_Valid, 1'b0);
        expect_word("ovr_word", {8'h11, 3'b000});

        send_frame(8'h5A, 2'b01, 1'b0, par_for(8'h5A, 2'b01), 1'b1, 1'b1, -1);
        drive_rx(1'b0, BIT_CLKS);
        drive_rx(1'b0, BIT_CLKS);
        drive_rx(1'b1, 80);
        Rx    = 1'b1;
        Rst_n = 1'b0;
        repeat (3) @(posedge SysClk);
        @(negedge SysClk);
        check_eq("mid_rst_data", Data_Out, 8'h00);
        check_eq("mid_rst_err", Rx_Error, 3'b000);
        check_eq("mid_rst_valid", Data_Valid, 1'b0);
        check_eq("mid_rst_ovr", Overrun, 1'b0);
        check_eq("mid_rst_busy", Busy, 1'b0);
        Rst_n      = 1'b1;
        Data_Ready = 1'b1;
        drive_rx(1'b1, 20);
        send_frame(8'h7E, 2'b01, 1'b0, par_for(8'h7E, 2'b01), 1'b1, 1'b1, -1);
        expect_word("after_rst", {8'h7E, 3'b000});

        ovr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            d    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            pm   = 2'($urandom_range(0, 3));
            ss   = 1'($urandom_range(0, 1));
            pbit = par_for(d, pm) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            exp  = model_frame(d, pm, ss, pbit, s1, s2);
            send_frame(d, pm, ss, pbit, s1, s2, -1);
            expect_word($sformatf("rnd%0d", k), exp);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 100);
            if (!(ss ? s2 : s1)) gap = gap + 20;
            if (gap > 0) drive_rx(1'b1, gap);
        end
        drive_rx(1'b1, 200);
        check_eq("rnd_no_ovr", ovr_cnt, 0);
        check_eq("no_extra_words", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver for the UART subsystem: next generation of the current fixed-format receive path. Synchronises the serial `Rx` line and uses a 3-sample majority vote at mid-bit. Supports run-time selection of parity mode and stop-bit count, and a parameter for bit order. Delivers each received word, with its error flags, through a one-entry valid/ready holding register; the word can feed the existing receive FIFO or the BIST comparator.

## Interface
- `SYSCLK_RATE`, 100000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bits/s.
- `OVERSAMPLE`, 16, sample ticks per bit; must be even and ≥8.
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `MSB_FIRST`, 1, 1 = MSB first (matches the current transmitter), 0 = LSB first.
- Derived: `CLKS_PER_TICK = SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE)`, integer-truncated; must be ≥2.

Ports:
- `SysClk` in 1: the single clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Rx` in 1: asynchronous serial input; idle level is high.
- `Parity_Mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `Stop_Sel` in 1: 0 = one stop bit, 1 = two stop bits.
- `Data_Out` out DATA_BITS: received word.
- `Rx_Error` out 3: error flags for the word; [0] break, [1] parity, [2] frame.
- `Data_Valid` out 1: holding register is full.
- `Data_Ready` in 1: consumer accepts the word.
- `Overrun` out 1: one-cycle pulse when a completed word is dropped.
- `Busy` out 1: a frame is in progress (any state other than IDLE).

## Operation
- **Input synchroniser:** 2-flop, reset to 1. All logic uses the synchronised `Rx` (`rx_s`).
- **Tick generator:** free-running counter of width `$clog2(CLKS_PER_TICK)`. It emits a 1-cycle tick every `CLKS_PER_TICK` clocks. It restarts at 0 on start-edge detection.
- **Bit sampling:** the sample counter counts 0..`OVERSAMPLE`-1 per bit. The bit value is the majority of `rx_s` at sample ticks `OVERSAMPLE/2`-1, `OVERSAMPLE/2` and `OVERSAMPLE/2`+1. The bit decision is made at sample `OVERSAMPLE/2`+1.
- **States:**
  - IDLE: a falling edge on `rx_s` → START.
  - START: at the mid-bit decision, majority 1 → IDLE (glitch rejected, no output). Majority 0 → DATA.
  - DATA: shift in `DATA_BITS` bits. The bit counter is `$clog2(DATA_BITS+1)` wide. After the last bit → PARITY if parity is enabled, else STOP.
  - PARITY: sample the parity bit. Even mode: expected bit = XOR of the data bits. Odd mode: the inverse. A mismatch sets the parity flag → STOP.
  - STOP: sample one or two stop bits. Any stop bit = 0 sets the frame flag. After the decision on the final stop bit, commit the word → IDLE.
  - BRK_WAIT: entered after commit of a break frame; → IDLE on the first `rx_s` = 1.
- **Break:** all data bits, the parity bit (if enabled) and the first stop bit are all 0. Result: `Rx_Error` = 001; the parity and frame flags are suppressed. The block commits the word immediately at the first-stop decision; with `Stop_Sel` = 1 the second stop bit is not sampled. It then enters BRK_WAIT.
- **Configuration latch:** `Parity_Mode` and `Stop_Sel` are latched at the START→DATA transition. Changes mid-frame affect only the next frame.
- **Commit:**
  - Holding register empty, or draining this cycle (`Data_Valid` & `Data_Ready`): load `Data_Out` and `Rx_Error`; `Data_Valid` = 1.
  - Otherwise: drop the new word, keep the old word, pulse `Overrun` for one cycle.
- **Handshake:** a transfer occurs when `Data_Valid` & `Data_Ready` are high on a `SysClk` edge. `Data_Valid` falls on the next cycle unless a commit happens in the same cycle; in that case it stays high with the new word and there is no overrun.
- **Reset (`Rst_n` low, at any time, including mid-frame):**
  - `Data_Out` = 0, `Rx_Error` = 000, `Data_Valid` = 0, `Overrun` = 0, `Busy` = 0, state = IDLE.
  - All counters = 0, synchroniser = 1.
  - A partial frame is discarded. After release, the receiver waits for a fresh falling edge.

## Timing
- Detection latency: 2 `SysClk` cycles from `Rx` edge to `rx_s`.
- A bit lasts `OVERSAMPLE * CLKS_PER_TICK` clocks.
- `Data_Valid` (or `Overrun`) asserts 1 cycle after the tick of the final bit decision:
  - normal frame: the last stop bit;
  - break frame: the first stop bit.
- Minimum frame-to-frame spacing: the last stop bit followed immediately by a start bit. This must be accepted without loss.
- `Busy` rises on the cycle after edge detection and falls on return to IDLE.

## Test plan
Bench configuration: `SYSCLK_RATE`=1600000, `BAUD_RATE`=10000, `OVERSAMPLE`=16 (10 clocks per tick, 160 per bit), `DATA_BITS`=8, `MSB_FIRST`=1. `Data_Ready`=1 unless stated.
- Even parity, 2 stop bits, send 0xA5 with parity 0 → `Data_Out`=0xA5, `Rx_Error`=000, `Data_Valid` for 1 cycle.
- Even parity, send 0xAA with parity bit 1 → `Data_Out`=0xAA, `Rx_Error`=010. Odd parity, 0xAA with parity 1 → `Rx_Error`=000.
- Send 0x55, correct parity, stop bits 0,0 → `Rx_Error`=100.
- Hold `Rx` low for 15 bit times, then high:
  - → `Rx_Error`=001, `Busy` high until `Rx` rises, then `Busy`=0;
  - a following 0x3C frame → received correctly.
- Glitches:
  - `Rx` low for 40 clocks → no `Data_Valid`, `Busy` back to 0 within one bit time;
  - noise pulse of 1 tick inside a data bit → the majority vote keeps the correct value.
- Overrun and reset:
  - `Data_Ready`=0, send 0x11 then 0x22 back-to-back → `Data_Out` stays 0x11, `Overrun` pulses once;
  - `Data_Ready`=1 for 1 cycle → `Data_Valid` falls;
  - assert `Rst_n` mid-frame → all outputs 0, and the next frame 0x7E is received cleanly.
